// File: rtl/adder_share_arbiter.sv
// Round-robin sequencer that shares one load-then-add accumulator among N_REQ requesters.
// Each served request takes three cycles: grant/load a, add b, then a done pulse.
module adder_share_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned W     = 3,
    parameter int unsigned ID_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    input  logic [N_REQ*W-1:0] a_flat,
    input  logic [N_REQ*W-1:0] b_flat,
    output logic [N_REQ-1:0]  gnt,
    output logic              busy,
    output logic              done,
    output logic [ID_W-1:0]   done_id,
    output logic [W:0]        sum
);

    typedef enum logic [1:0] {
        StIdle,
        StAdd,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   win_q, win_d;
    logic [W-1:0]      acc_q, acc_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              done_q, done_d;
    logic [ID_W-1:0]   done_id_q, done_id_d;
    logic [W:0]        sum_q, sum_d;

    logic [W-1:0]      a_arr [N_REQ];
    logic [W-1:0]      b_arr [N_REQ];

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic               found;
    logic [ID_W-1:0]    winner;
    int unsigned        off;
    int unsigned        idx;

    // Unpack the flat operand buses into per-requester words.
    always_comb begin
        for (int i = 0; i < int'(N_REQ); i++) begin
            a_arr[i] = a_flat[i*W +: W];
            b_arr[i] = b_flat[i*W +: W];
        end
    end

    // Rotate req so bit 0 is the requester at ptr, then take the lowest set bit.
    always_comb begin
        req_dbl = {req, req};
        req_rot = N_REQ'(req_dbl >> ptr_q);
        found   = |req_rot;
        off     = 0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                off = i;
            end
        end
        idx = 32'(ptr_q) + off;
        if (idx >= N_REQ) begin
            idx = idx - N_REQ;
        end
        winner = ID_W'(idx);
    end

    // Next-state logic: hold everything by default, advance one phase per cycle.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        acc_d     = acc_q;
        gnt_d     = gnt_q;
        done_d    = done_q;
        done_id_d = done_id_q;
        sum_d     = sum_q;

        case (state_q)
            StIdle: begin
                if (found) begin
                    win_d   = winner;
                    gnt_d   = N_REQ'(1) << winner;
                    acc_d   = a_arr[winner];
                    state_d = StAdd;
                end
            end
            StAdd: begin
                // Zero-extended add; W+1 bits always holds the result.
                sum_d     = {1'b0, acc_q} + {1'b0, b_arr[win_q]};
                done_d    = 1'b1;
                done_id_d = win_q;
                state_d   = StDone;
            end
            StDone: begin
                done_d  = 1'b0;
                gnt_d   = '0;
                // Served requester drops to lowest priority next round.
                ptr_d   = (win_q == ID_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            win_q     <= '0;
            acc_q     <= '0;
            gnt_q     <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            sum_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            acc_q     <= acc_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            sum_q     <= sum_d;
        end
    end

    assign gnt     = gnt_q;
    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign done_id = done_id_q;
    assign sum     = sum_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with a result scoreboard.
module tb_adder_share_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [11:0] a_flat;
    logic [11:0] b_flat;
    logic [3:0]  gnt;
    logic        busy;
    logic        done;
    logic [1:0]  done_id;
    logic [3:0]  sum;

    int vectors;
    int errs;
    int done_cnt;
    logic [5:0] sb [$];

    adder_share_arbiter #(
        .N_REQ (4),
        .W     (3),
        .ID_W  (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .a_flat  (a_flat),
        .b_flat  (b_flat),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .sum     (sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard: every done pulse must match the oldest expected {id, sum}.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'(0));
            end else begin
                logic [5:0] e;
                e = sb.pop_front();
                check("done_id", 32'(done_id), 32'(e[5:4]));
                check("sum", 32'(sum), 32'(e[3:0]));
            end
        end
    end

    // One request pattern whose winner is id; req drops right after the grant.
    task automatic run_req(input logic [3:0] pattern, input int id,
                           input logic [2:0] a, input logic [2:0] b);
        logic [3:0] s;
        s = {1'b0, a} + {1'b0, b};
        a_flat[id*3 +: 3] = a;
        b_flat[id*3 +: 3] = b;
        sb.push_back({2'(id), s});
        req = pattern;
        tick();
        check("gnt_onehot", 32'(gnt), 32'(4'b0001 << id));
        check("busy_grant", 32'(busy), 32'(1));
        req = '0;
        tick();
        tick();
        check("gnt_clear", 32'(gnt), 32'(0));
        check("busy_idle", 32'(busy), 32'(0));
        check("sum_hold", 32'(sum), 32'(s));
    endtask

    initial begin
        int d0;
        vectors  = 0;
        errs     = 0;
        done_cnt = 0;
        rst      = 1'b1;
        req      = '0;
        a_flat   = '0;
        b_flat   = '0;

        // Reset state
        #1;
        check("rst_gnt", 32'(gnt), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_sum", 32'(sum), 32'(0));
        check("rst_done_id", 32'(done_id), 32'(0));
        tick();
        rst = 1'b0;
        tick();

        // Single request: 3 + 5
        run_req(4'b0001, 0, 3'd3, 3'd5);

        // Continuous all-request round robin from a fresh ptr
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_flat[i*3 +: 3] = 3'(i);
            b_flat[i*3 +: 3] = 3'd7;
        end
        for (int i = 0; i < 5; i++) begin
            sb.push_back({2'(i % 4), 4'(7 + (i % 4))});
        end
        d0 = done_cnt;
        req = 4'b1111;
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        req = '0;
        check("rr_done_count", 32'(done_cnt - d0), 32'(5));
        check("rr_sb_empty", 32'(sb.size()), 32'(0));
        check("rr_busy_idle", 32'(busy), 32'(0));

        // Boundary arithmetic (ptr now 1)
        run_req(4'b0010, 1, 3'd7, 3'd7);
        run_req(4'b0100, 2, 3'd0, 3'd0);

        // Priority wrap
        run_req(4'b1000, 3, 3'd1, 3'd1);
        run_req(4'b1001, 0, 3'd2, 3'd3);
        run_req(4'b1001, 3, 3'd4, 3'd2);

        // Withdrawal during ADD (ptr now 0)
        run_req(4'b0001, 0, 3'd5, 3'd6);

        // Reset during ADD (ptr now 1)
        a_flat[3 +: 3] = 3'd3;
        b_flat[3 +: 3] = 3'd3;
        d0 = done_cnt;
        req = 4'b0010;
        tick();
        check("pre_rst_gnt", 32'(gnt), 32'(4'b0010));
        #1;
        rst = 1'b1;
        req = '0;
        #1;
        check("async_gnt", 32'(gnt), 32'(0));
        check("async_busy", 32'(busy), 32'(0));
        check("async_done", 32'(done), 32'(0));
        check("async_sum", 32'(sum), 32'(0));
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("no_done_after_rst", 32'(done_cnt - d0), 32'(0));
        run_req(4'b1111, 0, 3'd1, 3'd2);

        // Operand sampling (ptr now 1): a at grant edge, b at ADD edge
        a_flat[3 +: 3] = 3'd2;
        b_flat[3 +: 3] = 3'd1;
        req = 4'b0010;
        tick();
        check("samp_gnt", 32'(gnt), 32'(4'b0010));
        req = '0;
        a_flat[3 +: 3] = 3'd7;
        b_flat[3 +: 3] = 3'd4;
        sb.push_back({2'd1, 4'd6});
        tick();
        tick();
        check("samp_sum", 32'(sum), 32'(6));

        check("sb_drained", 32'(sb.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one 3-bit load-then-add accumulator among N requesters.
- Each requester presents two operands plus a req line. The block:
  - grants one requester,
  - loads its first operand,
  - adds the second operand,
  - returns a (W+1)-bit sum with a one-cycle done pulse tagged with the requester id.
- Sits between the operand sources and the shared summer datapath; it is the only writer of the accumulator.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 3, operand width in bits; the sum is W+1 bits.
- ID_W, 2, width of the requester id; equals ceil(log2(N_REQ)).

Ports:
- clk     input   1          rising-edge clock.
- rst     input   1          asynchronous, active-high reset.
- req     input   N_REQ      request lines, bit i = requester i; level-sensitive.
- a_flat  input   N_REQ*W    first operands; requester i occupies bits [i*W +: W].
- b_flat  input   N_REQ*W    second operands, same packing.
- gnt     output  N_REQ      one-hot grant; all zero when idle.
- busy    output  1          high whenever state is not IDLE.
- done    output  1          one-cycle pulse; sum and done_id are valid in that cycle.
- done_id output  ID_W       index of the requester whose sum is on sum.
- sum     output  W+1        registered result a+b of the last completed operation.

Behaviour:
- Reset (async, rst=1): state=IDLE, ptr=0, acc=0, gnt=0, done=0, done_id=0, sum=0, busy=0. Every output reads zero while rst is held.
- State encoding: IDLE, ADD, DONE. The winner index is registered as win.
- Arbitration, evaluated only in IDLE: search req starting at index ptr, wrapping modulo N_REQ. The first set bit wins.
- IDLE:
  - No req: stay in IDLE; all registers hold.
  - Any req: at the clock edge, win<=winner, gnt<=onehot(winner), acc<=a_flat[winner], state<=ADD.
- ADD:
  - At the edge: sum<=acc+b_flat[win], zero-extended to W+1 bits. Overflow is impossible (max 2*(2^W-1)).
  - At the same edge: done<=1, done_id<=win, state<=DONE.
  - req is ignored in this state.
- DONE:
  - done is high for exactly this cycle.
  - At the edge: done<=0, gnt<=0, ptr<=(win+1) mod N_REQ, state<=IDLE.
  - req is ignored, which lets the finished requester drop req after seeing done.
- Latency:
  - req sampled high at edge E0 → done high after edge E0+1 → back to IDLE after E0+2.
  - Earliest next grant is at edge E0+3, giving one operation per 3 cycles.
- Operand sampling: a is sampled at the grant edge, b at the ADD edge. The requester holds both operands stable while its gnt is high.
- Request withdrawal: if a granted requester drops req mid-operation, the operation still completes and done still pulses (committed transaction).
- Fairness: after requester k is served, k has the lowest priority in the next arbitration. With all lines requesting continuously, grant order is 0,1,2,3,0,...
- sum and done_id hold their values after done falls, until the next ADD edge.
- Reset mid-operation: every register returns to its reset value immediately. The in-flight result is discarded and no done is produced.
- gnt is always one-hot or zero, never multi-hot.

Test Plan:
1. Reset, then req=0001, a0=3, b0=5 → gnt=0001 after the next edge; one cycle later done=1, sum=8, done_id=0; gnt=0 after DONE.
2. req=1111 held continuously, with a_i=i and b_i=7 → done_id sequence 0,1,2,3,0, with sums 7,8,9,10,7. Exactly one done every 3 cycles.
3. Boundary arithmetic: a=7, b=7 → sum=14 (4'b1110). a=0, b=0 → sum=0 with done still pulsing.
4. Priority wrap: serve requester 3, then raise req=1001 → requester 0 is granted. Serve 0, then raise req=1001 again → requester 3 is granted.
5. Withdrawal and reset:
   - Drop req while in ADD → done still pulses with the correct sum.
   - Assert rst during ADD → gnt, busy and done fall asynchronously to 0, sum=0, no done pulse, ptr=0 afterwards.
6. Operand sampling: change b_flat between the grant edge and the ADD edge → sum uses the b value present at the ADD edge. Changing a after the grant edge has no effect.
